// File: rtl/arcade_input_cond.sv
// arcade_input_cond: PS/2 key latches, joystick merge/rotation and frame-timed coin pulses into active-low input bytes.
// Define INPUT_AUTO_COIN_EN to make either start also request coin 1.
module arcade_input_cond #(
    parameter int COIN_FRAMES = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joy,
    input  logic [15:0] joy2,
    input  logic        rotate,
    input  logic        I_VBLANK,
    output logic [7:0]  in0_reg,
    output logic [7:0]  in1_reg
);
    localparam int CW = $clog2(COIN_FRAMES + 1);
    localparam logic [CW-1:0] LAST = CW'(COIN_FRAMES - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, HOLDOFF} coin_st_t;

    logic        old_tog_q, old_tog_d;
    logic [17:0] keys_q, keys_d, hit;
    logic        vb_q, vb_d, vb_rise;
    logic [1:0]  req, req_q, req_d, rise, coin;
    logic [7:0]  in0_d, in1_d;
    logic        u1, d1, l1, r1, u2, d2, l2, r2, start1, start2;
    logic        unused_ok;

    assign unused_ok = ^{joy[15:7], joy2[15:7]};

    always_comb begin
        // Arrow keys match on the low byte so extended and keypad arrows both count
        hit = {ps2_key[8:0] == 9'h02C, ps2_key[8:0] == 9'h01C, ps2_key[8:0] == 9'h034,
               ps2_key[8:0] == 9'h023, ps2_key[8:0] == 9'h02B, ps2_key[8:0] == 9'h02D,
               ps2_key[8:0] == 9'h036, ps2_key[8:0] == 9'h02E, ps2_key[8:0] == 9'h01E,
               ps2_key[8:0] == 9'h006, ps2_key[8:0] == 9'h016, ps2_key[8:0] == 9'h005,
               ps2_key[8:0] == 9'h014, ps2_key[8:0] == 9'h029,
               ps2_key[7:0] == 8'h74, ps2_key[7:0] == 8'h6B,
               ps2_key[7:0] == 8'h72, ps2_key[7:0] == 8'h75};
        keys_d = (ps2_key[10] != old_tog_q) ? ((keys_q & ~hit) | (hit & {18{ps2_key[9]}})) : keys_q;
        old_tog_d = ps2_key[10];
        vb_d = I_VBLANK;
        vb_rise = I_VBLANK & ~vb_q;
        u1 = rotate ? (keys_q[2] | joy[1]) : (keys_q[0] | joy[3]);
        d1 = rotate ? (keys_q[3] | joy[0]) : (keys_q[1] | joy[2]);
        l1 = rotate ? (keys_q[1] | joy[2]) : (keys_q[2] | joy[1]);
        r1 = rotate ? (keys_q[0] | joy[3]) : (keys_q[3] | joy[0]);
        u2 = rotate ? (keys_q[14] | joy2[1]) : (keys_q[12] | joy2[3]);
        d2 = rotate ? (keys_q[15] | joy2[0]) : (keys_q[13] | joy2[2]);
        l2 = rotate ? (keys_q[13] | joy2[2]) : (keys_q[14] | joy2[1]);
        r2 = rotate ? (keys_q[12] | joy2[3]) : (keys_q[15] | joy2[0]);
        start1 = keys_q[6] | keys_q[7] | joy[5] | joy2[5];
        start2 = keys_q[8] | keys_q[9] | joy[6] | joy2[6];
`ifdef INPUT_AUTO_COIN_EN
        req = {keys_q[11], keys_q[10] | start1 | start2};
`else
        req = {keys_q[11], keys_q[10]};
`endif
        req_d = req;
        rise = req & ~req_q;
        in0_d = ~{coin[1], 1'b0, coin[0], keys_q[17], d1, r1, l1, u1};
        in1_d = ~{keys_q[16] | joy2[4], start2, start1, keys_q[4] | keys_q[5] | joy[4], d2, r2, l2, u2};
    end

    always_ff @(posedge CLK) begin
        old_tog_q <= old_tog_d;
        if (RESET) begin
            keys_q  <= '0;
            vb_q    <= 1'b0;
            req_q   <= '0;
            in0_reg <= 8'hFF;
            in1_reg <= 8'hFF;
        end else begin
            keys_q  <= keys_d;
            vb_q    <= vb_d;
            req_q   <= req_d;
            in0_reg <= in0_d;
            in1_reg <= in1_d;
        end
    end

    for (genvar c = 0; c < 2; c++) begin : g_coin
        coin_st_t      st_q;
        logic [CW-1:0] cnt_q;
        logic          pend_q;
        assign coin[c] = (st_q == ACTIVE);
        always_ff @(posedge CLK) begin
            if (RESET) begin
                st_q   <= IDLE;
                cnt_q  <= '0;
                pend_q <= 1'b0;
            end else begin
                case (st_q)
                    IDLE: if (rise[c]) begin
                        st_q  <= ACTIVE;
                        cnt_q <= '0;
                    end
                    ACTIVE: begin
                        if (rise[c]) pend_q <= 1'b1;
                        if (vb_rise) begin
                            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
                            if (cnt_q == LAST) st_q <= HOLDOFF;
                        end
                    end
                    HOLDOFF: if (vb_rise && cnt_q == LAST) begin
                        // A request arriving on the final hold-off edge is queued, not lost
                        st_q   <= (pend_q | rise[c]) ? ACTIVE : IDLE;
                        cnt_q  <= '0;
                        pend_q <= 1'b0;
                    end else begin
                        if (vb_rise) cnt_q <= cnt_q + 1'b1;
                        if (rise[c]) pend_q <= 1'b1;
                    end
                    default: st_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/arcade_input_cond.md
# arcade_input_cond

Input-conditioning stage directly upstream of the `pacman` core's `in0_reg`/`in1_reg` ports.
- Decodes the HPS PS/2 key stream into held key latches and merges them with both joystick words.
- Applies the vertical/horizontal orientation remap.
- Turns coin requests into frame-timed coin pulses that the game's per-frame coin poll cannot miss.
- Drives registered, active-low input bytes.

## Interface
Parameters:
- `COIN_FRAMES`, 4: number of VBLANK rising edges a coin stays asserted, and the number of edges in the following hold-off.

Ports:
- Clock and reset: one clock, `CLK`; reset is synchronous and active-high, `RESET`.
- `CLK` in 1: system clock (`clk_sys`).
- `RESET` in 1: synchronous, active-high reset.
- `ps2_key` in 11: [10] toggle, [9] pressed, [8:0] extended scan code.
- `joy` in 16: player 1 joystick. [0]R [1]L [2]D [3]U [4]fire [5]start1 [6]start2.
- `joy2` in 16: player 2 joystick, same map.
- `rotate` in 1: 1 = horizontal orientation remap (status[2]).
- `I_VBLANK` in 1: vertical blank from the core.
- `in0_reg` out 8: active-low {coin2, 0, coin1, test, down, right, left, up}.
- `in1_reg` out 8: active-low {fire2, start2, start1, fire2-unused→fire, down2, right2, left2, up2}. Exact order: {fire_2, start2, start1, fire, down_2, right_2, left_2, up_2}.

## Operation
- **Key latch.** `old_tog` register. When `ps2_key[10] != old_tog`, the latch selected by `ps2_key[8:0]` is loaded with `ps2_key[9]`. The ext bit is ignored for arrows (X75/X72/X6B/X74).
- **Key map.**
  - Player 1: 029/014 fire; 005 and 016 start1; 006 and 01E start2; 02E coin1; 036 coin2.
  - Player 2: 02D up2; 02B down2; 023 left2; 034 right2; 01C fire2.
  - Test: 02C.
  - Unlisted codes: no effect.
- **Direction merge, `rotate=0`.**
  - up = key_up | joy[3]
  - down = key_down | joy[2]
  - left = key_left | joy[1]
  - right = key_right | joy[0]
- **Direction merge, `rotate=1`.**
  - up = key_left | joy[1]
  - down = key_right | joy[0]
  - left = key_down | joy[2]
  - right = key_up | joy[3]
- Player 2 uses the same remap with its own keys and `joy2`.
- **Starts.**
  - start1 = keys | joy[5] | joy2[5]
  - start2 = keys | joy[6] | joy2[6]
- **Coin request.** Coin request 1 = coin1 key (| start1 | start2 when auto-coin is enabled); request 2 = coin2 key. Each channel detects the rising edge of its request level.
- **Coin FSM, one per channel.**
  - IDLE: on a request edge → ACTIVE, counter = 0.
  - ACTIVE: coin asserted. Each VBLANK rising edge increments the counter; at COIN_FRAMES → HOLDOFF, counter = 0.
  - HOLDOFF: coin deasserted. At COIN_FRAMES edges → IDLE, or → ACTIVE directly if `pending` is set (clear `pending`).
- A request edge during ACTIVE/HOLDOFF sets `pending`. Further edges while pending are dropped, so at most one request is queued.
- Counter width is `$clog2(COIN_FRAMES+1)`; no wrap occurs.
- Output bytes are the bitwise inverse of the assembled active-high vectors. `in0_reg[6]` is constantly 1.

## Timing
- **Reset.**
  - All key latches = 0.
  - FSMs IDLE, counters 0, `pending` = 0.
  - `in0_reg` = `in1_reg` = 8'hFF.
  - `old_tog` loads the current `ps2_key[10]`, so reset creates no spurious key event.
  - Reset mid-pulse aborts the pulse with no queued coin.
- **Latency.**
  - Joystick/rotate change → output: 1 cycle.
  - PS/2 toggle → output: 2 cycles (latch, then output register).
- **Coin timing.**
  - Request edge → coin low on the output 2 cycles later.
  - Coin deasserts on the cycle after the COIN_FRAMES-th VBLANK rising edge is registered.
- **Simultaneous events.**
  - A request edge and a VBLANK edge in the same cycle while IDLE: the request wins and the VBLANK edge is not counted.
  - A request edge in the same cycle as HOLDOFF→IDLE: treated as pending, so it goes straight to ACTIVE.
- `rotate` may change at any time and takes effect on the next cycle; there is no glitch filtering.

## Configuration
- `INPUT_AUTO_COIN_EN` defined: start1 or start2 (any source) also raises coin request 1, giving free-play-style coin-on-start.
- Undefined: coin 1 comes only from the 02E key. Starts only drive `in1_reg` bits 5/6.

## Test plan
- **Reset.** RESET high 3 cycles → `in0_reg` = `in1_reg` = 8'hFF. No coin pulse after release, even when `ps2_key[10]` = 1.
- **Rotation.** `joy` = 16'h0008, `rotate`=0 → `in0_reg` = 8'hFE after 1 cycle. `rotate`=1 with `joy` = 16'h0002 → 8'hFE.
- **Key hold.** Toggle with code 029 pressed → `in1_reg` = 8'hEF after 2 cycles. Toggle with 029 released → 8'hFF.
- **Coin pulse.** COIN_FRAMES=4, key 02E pressed → `in0_reg[5]` = 0 for exactly 4 VBLANK edges, then 1 for 4 edges.
- **Pending queue.** Three coin edges during ACTIVE → exactly two total pulses, separated by the hold-off.
- **Auto-coin.** With `INPUT_AUTO_COIN_EN`, `joy`[5] rising → `in0_reg[5]` pulses and `in1_reg[5]` = 0. Without the macro → `in0_reg[5]` stays 1.
